reg_dump_sequencer: RTL and testbench

Sequencer that copies the 32 architectural registers into the character screen RAM as hex text, so the VGA text view shows a register snapshot. It runs once per processor step. For each register it drives the register-file debug read select, captures the value, and writes 10 ASCII characters ("0x" followed by 8 hex digits) into the screen RAM write port, one character per cycle, under a ready handshake. It sits between the CPU step logic, the register file debug read port and the screen RAM.

---
 rtl/reg_dump_sequencer.sv | 157 +++++++++++++++
 tb/tb_reg_dump_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_sequencer.sv
// reg_dump_sequencer
//   Copies the 32 architectural registers into the character screen RAM as
//   hex text ("0x" + 8 uppercase hex digits per register). One dump per start
//   pulse; start pulses that arrive while a dump is running collapse into one
//   follow-up dump.
//
// Ports
//   clock, reset      system clock, synchronous active-high reset
//   start             one-cycle dump request
//   reg_data          register file debug read data (combinational from reg_select)
//   wr_ready          screen RAM accepts a write this cycle
//   reg_select        register file debug read select
//   scr_wr_en         screen RAM write strobe
//   scr_wr_addr       screen RAM write address, {row[4:0], col[6:0]}
//   scr_wr_data       ASCII character to write
//   busy              dump in progress
//   done              one-cycle pulse after the last character of register 31
module reg_dump_sequencer #(
  parameter int COL0     = 11,
  parameter int COL1     = 33,
  parameter int COL2     = 56,
  parameter int BASE_ROW = 0,
  parameter int ADDR_W   = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       reg_data,
  input  logic              wr_ready,
  output logic [4:0]        reg_select,
  output logic              scr_wr_en,
  output logic [ADDR_W-1:0] scr_wr_addr,
  output logic [6:0]        scr_wr_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, FINISH} state_t;

  state_t      state_q, state_d;
  logic [4:0]  r_q, r_d;
  logic [3:0]  k_q, k_d;
  logic        pending_q, pending_d;
  logic [31:0] shadow_q, shadow_d;

  logic [4:0]  row;
  logic [6:0]  col;

  function automatic logic [6:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) hex_ascii = 7'h30 + {3'b000, n};
    else           hex_ascii = 7'h37 + {3'b000, n};  // 10 -> 'A' (0x41)
  endfunction

  function automatic logic [6:0] char_at(input logic [3:0] k, input logic [31:0] v);
    case (k)
      4'd0:    char_at = 7'h30;
      4'd1:    char_at = 7'h78;
      4'd2:    char_at = hex_ascii(v[31:28]);
      4'd3:    char_at = hex_ascii(v[27:24]);
      4'd4:    char_at = hex_ascii(v[23:20]);
      4'd5:    char_at = hex_ascii(v[19:16]);
      4'd6:    char_at = hex_ascii(v[15:12]);
      4'd7:    char_at = hex_ascii(v[11:8]);
      4'd8:    char_at = hex_ascii(v[7:4]);
      4'd9:    char_at = hex_ascii(v[3:0]);
      default: char_at = 7'h30;
    endcase
  endfunction

  // Three screen columns of 11/11/10 registers; row and column wrap to 5/7 bits.
  always_comb begin
    if (r_q <= 5'd10) begin
      row = 5'(BASE_ROW) + r_q;
      col = 7'(COL0) + {3'b000, k_q};
    end else if (r_q <= 5'd21) begin
      row = 5'(BASE_ROW) + r_q - 5'd11;
      col = 7'(COL1) + {3'b000, k_q};
    end else begin
      row = 5'(BASE_ROW) + r_q - 5'd22;
      col = 7'(COL2) + {3'b000, k_q};
    end
  end

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    k_d         = k_q;
    shadow_d    = shadow_q;
    // Any start outside IDLE (including FINISH) queues exactly one more dump.
    pending_d   = pending_q | (start && (state_q != IDLE));
    reg_select  = r_q;
    scr_wr_en   = 1'b0;
    scr_wr_addr = '0;
    scr_wr_data = '0;
    busy        = (state_q != IDLE);
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start || pending_q) begin
          state_d   = LOAD;
          r_d       = 5'd0;
          pending_d = 1'b0;
        end
      end
      LOAD: begin
        // Snapshot once so later reg_data changes cannot corrupt this register's text.
        shadow_d = reg_data;
        k_d      = 4'd0;
        state_d  = WRITE;
      end
      WRITE: begin
        scr_wr_en   = wr_ready;
        scr_wr_addr = ADDR_W'({row, col});
        scr_wr_data = char_at(k_q, shadow_q);
        if (wr_ready) begin
          if (k_q == 4'd9) begin
            if (r_q == 5'd31) begin
              state_d = FINISH;
            end else begin
              r_d     = r_q + 5'd1;
              state_d = LOAD;
            end
          end else begin
            k_d = k_q + 4'd1;
          end
        end
      end
      FINISH: begin
        done    = 1'b1;
        r_d     = 5'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      r_q       <= 5'd0;
      k_q       <= 4'd0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      k_q       <= k_d;
      pending_q <= pending_d;
    end
  end

  // Data-only register: always reloaded in LOAD before use.
  always_ff @(posedge clock) begin
    shadow_q <= shadow_d;
  end

endmodule

// File: tb/tb_reg_dump_sequencer.sv
module tb_reg_dump_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] reg_data;
  logic        wr_ready;
  logic [4:0]  reg_select;
  logic        scr_wr_en;
  logic [11:0] scr_wr_addr;
  logic [6:0]  scr_wr_data;
  logic        busy;
  logic        done;

  reg_dump_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .reg_data    (reg_data),
    .wr_ready    (wr_ready),
    .reg_select  (reg_select),
    .scr_wr_en   (scr_wr_en),
    .scr_wr_addr (scr_wr_addr),
    .scr_wr_data (scr_wr_data),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  logic [31:0] regs [32];
  assign reg_data = regs[reg_select];

  int total = 0;
  int bad   = 0;
  int writes = 0;
  int dones  = 0;
  logic [18:0] exp_q [$];
  logic [6:0]  scr_mem [4096];
  logic        prev_stall = 1'b0;
  logic [11:0] prev_addr;
  logic [6:0]  prev_data;

  logic [6:0] x5_txt  [10] = '{7'h30, 7'h78, 7'h44, 7'h45, 7'h41, 7'h44, 7'h42, 7'h45, 7'h45, 7'h46};
  logic [6:0] x31_txt [10] = '{7'h30, 7'h78, 7'h31, 7'h32, 7'h33, 7'h34, 7'h35, 7'h36, 7'h37, 7'h38};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference model of one full dump, pushed when the dump is requested.
  task automatic push_dump();
    string hx;
    int row, col, nib;
    logic [6:0] ch;
    hx = "0123456789ABCDEF";
    for (int r = 0; r < 32; r++) begin
      if (r <= 10)      begin row = r;      col = 11; end
      else if (r <= 21) begin row = r - 11; col = 33; end
      else              begin row = r - 22; col = 56; end
      for (int k = 0; k < 10; k++) begin
        if (k == 0)      ch = 7'h30;
        else if (k == 1) ch = 7'h78;
        else begin
          nib = int'((regs[r] >> (4 * (9 - k))) & 32'hF);
          ch  = 7'(hx[nib]);
        end
        exp_q.push_back({12'(row * 128 + col + k), ch});
      end
    end
  endtask

  always @(negedge clock) begin
    if (prev_stall) begin
      check("stall_hold", {13'b0, scr_wr_addr, scr_wr_data}, {13'b0, prev_addr, prev_data});
    end
    prev_stall = (wr_ready === 1'b0) && (scr_wr_data !== 7'h00) && (reset === 1'b0);
    prev_addr  = scr_wr_addr;
    prev_data  = scr_wr_data;
    if (wr_ready === 1'b0) check("no_wr_when_not_ready", 32'(scr_wr_en), 32'd0);
    if (scr_wr_en === 1'b1) begin
      writes++;
      scr_mem[scr_wr_addr] = scr_wr_data;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL wr_unexpected observed addr=%0d data=%h expected=no write", scr_wr_addr, scr_wr_data);
      end else begin
        check("wr_seq", {13'b0, scr_wr_addr, scr_wr_data}, {13'b0, exp_q.pop_front()});
      end
    end
    if (done === 1'b1) dones++;
  end

  task automatic pulse_start();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input bit bp, output int busy_cycles, output bit ok);
    busy_cycles = 0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bp) wr_ready = ($urandom_range(0, 1) == 1);
      if (busy === 1'b1) busy_cycles++;
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  bc;
    bit  ok;
    bit  found;
    reset = 1'b1;
    start = 1'b0;
    wr_ready = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Idle: no start, outputs stay at zero.
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      check("idle_outputs", 32'({reg_select, scr_wr_en, scr_wr_addr, scr_wr_data, busy, done}), 32'd0);
    end
    check("idle_no_writes", writes, 0);

    // Single non-zero register, full-speed dump.
    regs[5] = 32'hDEADBEEF;
    writes = 0; dones = 0;
    push_dump();
    pulse_start();
    run_until_done(2000, 1'b0, bc, ok);
    check("t2_done_seen", 32'(ok), 32'd1);
    check("t2_dump_len", bc, 353);
    @(posedge clock); #1;
    check("t2_writes", writes, 320);
    check("t2_dones", dones, 1);
    check("t2_queue_empty", exp_q.size(), 0);
    check("t2_busy_after", 32'(busy), 32'd0);
    for (int k = 0; k < 10; k++) check("t2_x5_text", 32'(scr_mem[651 + k]), 32'(x5_txt[k]));

    // Column mapping.
    regs[5] = 32'h0; regs[12] = 32'h0000000A; regs[31] = 32'h12345678;
    writes = 0;
    push_dump();
    pulse_start();
    run_until_done(2000, 1'b0, bc, ok);
    check("t3_done_seen", 32'(ok), 32'd1);
    @(posedge clock); #1;
    check("t3_writes", writes, 320);
    check("t3_x12_last", 32'(scr_mem[170]), 32'h41);
    check("t3_x12_first", 32'(scr_mem[161]), 32'h30);
    for (int k = 0; k < 10; k++) check("t3_x31_text", 32'(scr_mem[1208 + k]), 32'(x31_txt[k]));

    // Backpressure with the same register contents.
    writes = 0;
    push_dump();
    pulse_start();
    run_until_done(4000, 1'b1, bc, ok);
    wr_ready = 1'b1;
    check("t4_done_seen", 32'(ok), 32'd1);
    check("t4_stretched", 32'(bc > 353), 32'd1);
    @(posedge clock); #1;
    check("t4_writes", writes, 320);
    check("t4_queue_empty", exp_q.size(), 0);

    // Two starts while busy collapse into one follow-up dump.
    writes = 0; dones = 0;
    push_dump();
    pulse_start();
    repeat (10) @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    repeat (50) @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    push_dump();
    run_until_done(2000, 1'b0, bc, ok);
    check("t5_first_done", 32'(ok), 32'd1);
    @(posedge clock); #1;
    run_until_done(2000, 1'b0, bc, ok);
    check("t5_second_done", 32'(ok), 32'd1);
    check("t5_second_len", bc, 353);
    repeat (20) @(posedge clock);
    #1;
    check("t5_writes", writes, 640);
    check("t5_dones", dones, 2);
    check("t5_queue_empty", exp_q.size(), 0);
    check("t5_idle_after", 32'(busy), 32'd0);

    // Reset in the middle of writing register 7.
    push_dump();
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (reg_select == 5'd7) begin found = 1'b1; break; end
      @(posedge clock); #1;
    end
    check("t6_reached_r7", 32'(found), 32'd1);
    repeat (4) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    check("t6_rst_wr_en", 32'(scr_wr_en), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    check("t6_rst_sel", 32'(reg_select), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    // start coincident with reset is dropped.
    @(posedge clock); #1 reset = 1'b1; start = 1'b1;
    @(posedge clock); #1 reset = 1'b0; start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      check("t6_start_under_reset", 32'(busy), 32'd0);
    end
    push_dump();
    pulse_start();
    check("t6_restart_sel", 32'(reg_select), 32'd0);
    @(posedge clock); #1;
    check("t6_restart_en", 32'(scr_wr_en), 32'd1);
    check("t6_restart_addr", 32'(scr_wr_addr), 32'd11);
    check("t6_restart_data", 32'(scr_wr_data), 32'h30);
    run_until_done(2000, 1'b0, bc, ok);
    check("t6_done_seen", 32'(ok), 32'd1);
    @(posedge clock); #1;
    check("t6_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
